// File: rtl/store_write_buffer_pkg.sv
// Shared types and constants for the store write buffer and its formatter.
package store_write_buffer_pkg;

  // Store width encodings carried on func3.
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // Default buffer geometry: WB_WIDTH = log2(WB_DEPTH).
  localparam int WB_DEPTH = 4;
  localparam int WB_WIDTH = 2;

  // One buffered, already-formatted, word-aligned write.
  typedef struct packed {
    logic        valid;
    logic [29:0] waddr;   // byte address bits [31:2]
    logic [31:0] wdata;   // lane-replicated data
    logic [3:0]  wstrb;   // byte enables
  } wb_entry_t;

endpackage : store_write_buffer_pkg

// File: rtl/store_write_buffer_format.sv
// Converts a right-justified store (func3 + low address bits) into a
// byte strobe and lane-replicated write data, and flags illegal
// width/alignment combinations. Purely combinational.
module store_write_buffer_format
  import store_write_buffer_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  input  logic [2:0]  func3,
  output logic [3:0]  strb,
  output logic [31:0] wdata,
  output logic        misaligned
);

  // Decode width, pick the byte lanes and replicate the data across them.
  always_comb begin
    strb       = 4'b0000;
    wdata      = 32'h0;
    misaligned = 1'b0;
    unique case (func3)
      F3_SB: begin
        strb  = 4'b0001 << addr_lo;
        wdata = {4{data[7:0]}};
      end
      F3_SH: begin
        strb       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{data[15:0]}};
        misaligned = addr_lo[0];
      end
      F3_SW: begin
        strb       = 4'b1111;
        wdata      = data;
        misaligned = (addr_lo != 2'b00);
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

endmodule : store_write_buffer_format

// File: rtl/store_write_buffer.sv
// Memory-side write buffer for retired stores. Formats each accepted
// store into a word-aligned strobed write, queues it in a small FIFO,
// drains the FIFO to data memory and forwards not-yet-written bytes to
// the load pipeline.
//
// Handshakes:
//   store side  : a store is taken on any edge where st_valid & st_ready;
//                 st_ready depends only on registered state. A store shown
//                 while st_ready is low is not taken.
//   memory side : dmem_wreq and its addr/data/strb stay stable until an
//                 edge where dmem_wack is high; that edge retires the head.
//                 dmem_wack with dmem_wreq low has no effect. Reset may
//                 withdraw a pending request.
module store_write_buffer #(
  parameter int WB_DEPTH = 4,
  parameter int WB_WIDTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  st_func3,
  output logic        st_ready,
  output logic        st_misaligned,
  output logic        dmem_wreq,
  output logic [31:0] dmem_waddr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_wack,
  input  logic [31:0] ld_addr,
  output logic        wb_fwd_valid,
  output logic [31:0] wb_fwd_data,
  output logic [3:0]  wb_fwd_byte_vector,
  output logic        wb_empty
);

  import store_write_buffer_pkg::*;

  wb_entry_t           entries_q [WB_DEPTH];
  logic [WB_WIDTH-1:0] head_q;
  logic [WB_WIDTH-1:0] tail_q;
  logic [WB_WIDTH:0]   count_q;
  logic                misaligned_q;

  logic [3:0]          fmt_strb;
  logic [31:0]         fmt_wdata;
  logic                fmt_misaligned;

  logic                accept;
  logic                enq;
  logic                deq;

  logic [WB_WIDTH-1:0] fwd_idx;
  logic [3:0]          fwd_vec;
  logic [31:0]         fwd_data;

  // Byte offset of the load is irrelevant to matching; whole words compare.
  logic                unused_ld_lo;
  assign unused_ld_lo = ^ld_addr[1:0];

  store_write_buffer_format u_format (
    .addr_lo    (st_addr[1:0]),
    .data       (st_data),
    .func3      (st_func3),
    .strb       (fmt_strb),
    .wdata      (fmt_wdata),
    .misaligned (fmt_misaligned)
  );

  assign st_ready      = (count_q < (WB_WIDTH+1)'(WB_DEPTH));
  assign accept        = st_valid & st_ready;
  assign enq           = accept & ~fmt_misaligned;
  assign deq           = dmem_wreq & dmem_wack;

  assign dmem_wreq     = entries_q[head_q].valid;
  assign dmem_waddr    = {entries_q[head_q].waddr, 2'b00};
  assign dmem_wdata    = entries_q[head_q].wdata;
  assign dmem_wstrb    = entries_q[head_q].wstrb;

  assign wb_empty      = (count_q == '0);
  assign st_misaligned = misaligned_q;

  // FIFO storage, pointers, occupancy and the one-cycle error pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < WB_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= accept & fmt_misaligned;
      // Head and tail only coincide when empty (no deq) or full (no enq),
      // so these two writes never target the same slot.
      if (enq) begin
        entries_q[tail_q] <= '{valid: 1'b1,
                               waddr: st_addr[31:2],
                               wdata: fmt_wdata,
                               wstrb: fmt_strb};
        tail_q <= tail_q + WB_WIDTH'(1);
      end
      if (deq) begin
        entries_q[head_q].valid <= 1'b0;
        head_q <= head_q + WB_WIDTH'(1);
      end
      unique case ({enq, deq})
        2'b10:   count_q <= count_q + (WB_WIDTH+1)'(1);
        2'b01:   count_q <= count_q - (WB_WIDTH+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Walk entries oldest to youngest so younger matching bytes overwrite
  // older ones; the head keeps forwarding until its write is acknowledged.
  always_comb begin
    fwd_idx  = '0;
    fwd_vec  = 4'b0000;
    fwd_data = 32'h0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      fwd_idx = head_q + WB_WIDTH'(i);
      if (entries_q[fwd_idx].valid &&
          (entries_q[fwd_idx].waddr == ld_addr[31:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (entries_q[fwd_idx].wstrb[b]) begin
            fwd_vec[b]         = 1'b1;
            fwd_data[8*b +: 8] = entries_q[fwd_idx].wdata[8*b +: 8];
          end
        end
      end
    end
  end

  assign wb_fwd_byte_vector = fwd_vec;
  assign wb_fwd_data        = fwd_data;
  assign wb_fwd_valid       = |fwd_vec;

endmodule : store_write_buffer

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: directed scenarios plus randomized traffic
// against a queue-based reference model of the buffered writes.
module tb_store_write_buffer;
  import store_write_buffer_pkg::*;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        st_valid = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [2:0]  st_func3 = '0;
  logic        st_ready;
  logic        st_misaligned;
  logic        dmem_wreq;
  logic [31:0] dmem_waddr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_wack = 1'b0;
  logic [31:0] ld_addr = '0;
  logic        wb_fwd_valid;
  logic [31:0] wb_fwd_data;
  logic [3:0]  wb_fwd_byte_vector;
  logic        wb_empty;

  int checks = 0;
  int errors = 0;

  // Scoreboard: writes accepted but not yet acknowledged, oldest first.
  // Packing: [67:36] word address, [35:4] write data, [3:0] strobe.
  logic [67:0] exp_q[$];
  logic        exp_mis = 1'b0;

  store_write_buffer #(.WB_DEPTH(4), .WB_WIDTH(2)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .st_valid           (st_valid),
    .st_addr            (st_addr),
    .st_data            (st_data),
    .st_func3           (st_func3),
    .st_ready           (st_ready),
    .st_misaligned      (st_misaligned),
    .dmem_wreq          (dmem_wreq),
    .dmem_waddr         (dmem_waddr),
    .dmem_wdata         (dmem_wdata),
    .dmem_wstrb         (dmem_wstrb),
    .dmem_wack          (dmem_wack),
    .ld_addr            (ld_addr),
    .wb_fwd_valid       (wb_fwd_valid),
    .wb_fwd_data        (wb_fwd_data),
    .wb_fwd_byte_vector (wb_fwd_byte_vector),
    .wb_empty           (wb_empty)
  );

  // ---------------- reference model ----------------
  // Byte b is written when it lies inside the naturally sized access;
  // its data is the store byte at the same offset within the access.
  function automatic void fmt_model(input logic [31:0] a, input logic [31:0] d,
                                    input logic [2:0] f3,
                                    output logic [67:0] w, output logic bad);
    int size;
    logic [3:0] s;
    logic [31:0] wd;
    case (f3)
      3'b000:  size = 1;
      3'b001:  size = 2;
      3'b010:  size = 4;
      default: size = 0;
    endcase
    s = '0;
    wd = '0;
    if (size == 0) begin
      bad = 1'b1;
    end else begin
      bad = ((int'(a[1:0]) % size) != 0);
      for (int b = 0; b < 4; b++) begin
        wd[8*b +: 8] = d[8*(b % size) +: 8];
        if ((b / size) == (int'(a[1:0]) / size)) s[b] = 1'b1;
      end
    end
    w = {a[31:2], 2'b00, wd, s};
  endfunction

  // Merge of all pending writes to the load's word, later writes winning.
  function automatic void fwd_model(input logic [31:0] la,
                                    output logic [3:0] v, output logic [31:0] dd);
    v = '0;
    dd = '0;
    foreach (exp_q[i]) begin
      if (exp_q[i][67:36] == {la[31:2], 2'b00}) begin
        for (int b = 0; b < 4; b++) begin
          if (exp_q[i][b]) begin
            v[b] = 1'b1;
            dd[8*b +: 8] = exp_q[i][4 + 8*b +: 8];
          end
        end
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_func3 = f3;
  endtask

  // Advance one clock; the scoreboard checks any write the memory takes.
  task automatic tick();
    logic [67:0] w;
    logic bad, acc, drn;
    fmt_model(st_addr, st_data, st_func3, w, bad);
    acc = reset_n && st_valid && (exp_q.size() < DEPTH);
    drn = reset_n && dmem_wack && (exp_q.size() > 0);
    if (drn) begin
      checks++;
      if ({dmem_wreq, dmem_waddr, dmem_wdata, dmem_wstrb} !== {1'b1, exp_q[0]}) begin
        errors++;
        $display("FAIL drain_write: got wreq=%b addr=%h data=%h strb=%b, expected wreq=1 addr=%h data=%h strb=%b",
                 dmem_wreq, dmem_waddr, dmem_wdata, dmem_wstrb, exp_q[0][67:36], exp_q[0][35:4], exp_q[0][3:0]);
      end
    end
    @(posedge clk);
    if (!reset_n) begin
      exp_q.delete();
      exp_mis = 1'b0;
    end else begin
      if (drn) void'(exp_q.pop_front());
      if (acc && !bad) exp_q.push_back(w);
      exp_mis = acc && bad;
    end
    #1;
  endtask

  task automatic drain_all();
    int n;
    n = 0;
    st_valid = 1'b0;
    dmem_wack = 1'b1;
    while (exp_q.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    dmem_wack = 1'b0;
    #1;
    checks++;
    if (wb_empty !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: wb_empty=%b pending=%0d after %0d cycles, expected empty", wb_empty, exp_q.size(), n);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    st_valid = 1'b0;
    dmem_wack = 1'b0;
    ld_addr = 32'h0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    checks++;
    if ({st_ready, wb_empty, dmem_wreq, st_misaligned, wb_fwd_valid, wb_fwd_byte_vector} !== 9'b11_000_0000) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b empty=%b wreq=%b mis=%b fwd=%b vec=%b, expected 1 1 0 0 0 0000",
               st_ready, wb_empty, dmem_wreq, st_misaligned, wb_fwd_valid, wb_fwd_byte_vector);
    end
  endtask

  task automatic test_sb_basic();
    dmem_wack = 1'b1;
    drive_store(32'h103, 32'hAB, F3_SB);
    tick();
    st_valid = 1'b0;
    #1;
    checks++;
    if ({dmem_wreq, dmem_waddr, dmem_wdata, dmem_wstrb} !== {1'b1, 32'h100, 32'hABABABAB, 4'b1000}) begin
      errors++;
      $display("FAIL sb_format: wreq=%b addr=%h data=%h strb=%b, expected 1 00000100 abababab 1000",
               dmem_wreq, dmem_waddr, dmem_wdata, dmem_wstrb);
    end
    tick();
    checks++;
    if (wb_empty !== 1'b1 || dmem_wreq !== 1'b0) begin
      errors++;
      $display("FAIL sb_empty_after_ack: empty=%b wreq=%b, expected 1 0", wb_empty, dmem_wreq);
    end
    dmem_wack = 1'b0;
  endtask

  task automatic test_fill_stall();
    dmem_wack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_store(32'h400 + 32'(4*i), $urandom, F3_SW);
      tick();
    end
    st_valid = 1'b0;
    #1;
    checks++;
    if (st_ready !== 1'b0 || wb_empty !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: ready=%b empty=%b, expected 0 0", st_ready, wb_empty);
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({dmem_wreq, dmem_waddr, dmem_wdata, dmem_wstrb} !== {1'b1, exp_q[0]}) begin
        errors++;
        $display("FAIL head_stable: wreq=%b addr=%h data=%h strb=%b, expected 1 %h %h %b",
                 dmem_wreq, dmem_waddr, dmem_wdata, dmem_wstrb, exp_q[0][67:36], exp_q[0][35:4], exp_q[0][3:0]);
      end
      tick();
    end
    dmem_wack = 1'b1;
    tick();
    dmem_wack = 1'b0;
    #1;
    checks++;
    if (st_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_ack: ready=%b, expected 1", st_ready);
    end
    drain_all();
  endtask

  task automatic test_forward();
    logic [3:0] ev;
    logic [31:0] ed;
    dmem_wack = 1'b0;
    drive_store(32'h200, 32'h11223344, F3_SW);
    tick();
    drive_store(32'h201, 32'hAA, F3_SB);
    tick();
    st_valid = 1'b0;
    ld_addr = 32'h202;
    #1;
    checks++;
    if ({wb_fwd_valid, wb_fwd_byte_vector, wb_fwd_data} !== {1'b1, 4'b1111, 32'h1122AA44}) begin
      errors++;
      $display("FAIL fwd_merge: valid=%b vec=%b data=%h, expected 1 1111 1122aa44",
               wb_fwd_valid, wb_fwd_byte_vector, wb_fwd_data);
    end
    ld_addr = 32'h204;
    #1;
    checks++;
    if ({wb_fwd_valid, wb_fwd_byte_vector, wb_fwd_data} !== {1'b0, 4'b0000, 32'h0}) begin
      errors++;
      $display("FAIL fwd_no_match: valid=%b vec=%b data=%h, expected 0 0000 00000000",
               wb_fwd_valid, wb_fwd_byte_vector, wb_fwd_data);
    end
    // Add a halfword to the same word and probe from several offsets.
    drive_store(32'h202, $urandom, F3_SH);
    tick();
    st_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ld_addr = 32'h200 + 32'($urandom_range(0, 7));
      #1;
      fwd_model(ld_addr, ev, ed);
      checks++;
      if ({wb_fwd_valid, wb_fwd_byte_vector, wb_fwd_data} !== {|ev, ev, ed}) begin
        errors++;
        $display("FAIL fwd_probe: ld=%h valid=%b vec=%b data=%h, expected %b %b %h",
                 ld_addr, wb_fwd_valid, wb_fwd_byte_vector, wb_fwd_data, |ev, ev, ed);
      end
    end
    drain_all();
  endtask

  task automatic test_misaligned();
    logic [31:0] bad_addr [3];
    logic [2:0]  bad_f3 [3];
    bad_addr[0] = 32'h301; bad_f3[0] = F3_SH;
    bad_addr[1] = 32'h300; bad_f3[1] = 3'b011;
    bad_addr[2] = 32'h302; bad_f3[2] = F3_SW;
    dmem_wack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_store(bad_addr[i], $urandom, bad_f3[i]);
      tick();
      st_valid = 1'b0;
      #1;
      checks++;
      if ({st_misaligned, dmem_wreq, wb_empty} !== 3'b101) begin
        errors++;
        $display("FAIL misaligned_pulse[%0d]: mis=%b wreq=%b empty=%b, expected 1 0 1",
                 i, st_misaligned, dmem_wreq, wb_empty);
      end
      tick();
      checks++;
      if ({st_misaligned, dmem_wreq, wb_empty} !== 3'b001) begin
        errors++;
        $display("FAIL misaligned_one_cycle[%0d]: mis=%b wreq=%b empty=%b, expected 0 0 1",
                 i, st_misaligned, dmem_wreq, wb_empty);
      end
    end
  endtask

  task automatic test_back_to_back();
    int sent;
    bool_fill: for (int i = 0; i < 4; i++) begin
      drive_store(32'h500 + 32'(4*i), $urandom, F3_SW);
      tick();
    end
    sent = 4;
    dmem_wack = 1'b1;
    drive_store(32'h500 + 32'(4*(sent % 4)), $urandom, F3_SW);
    for (int c = 0; c < 16 && sent < 14; c++) begin
      #1;
      checks++;
      if (st_ready !== (exp_q.size() < DEPTH) || wb_empty !== (exp_q.size() == 0)) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: ready=%b empty=%b, expected %b %b",
                 c, st_ready, wb_empty, exp_q.size() < DEPTH, exp_q.size() == 0);
      end
      if (exp_q.size() < DEPTH) begin
        tick();
        sent++;
        drive_store(32'h500 + 32'(4*(sent % 4)), $urandom, F3_SW);
      end else begin
        tick();
      end
    end
    drain_all();
  endtask

  task automatic test_reset_mid_drain();
    dmem_wack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_store(32'h600 + 32'(4*i), $urandom, F3_SW);
      tick();
    end
    st_valid = 1'b0;
    ld_addr = 32'h600;
    #1;
    checks++;
    if (wb_fwd_valid !== 1'b1 || dmem_wreq !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_state: fwd=%b wreq=%b, expected 1 1", wb_fwd_valid, dmem_wreq);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    checks++;
    if ({dmem_wreq, wb_empty, wb_fwd_valid, st_ready} !== 4'b0101) begin
      errors++;
      $display("FAIL reset_mid_drain: wreq=%b empty=%b fwd=%b ready=%b, expected 0 1 0 1",
               dmem_wreq, wb_empty, wb_fwd_valid, st_ready);
    end
  endtask

  task automatic test_random();
    logic [3:0] ev;
    logic [31:0] ed;
    logic [2:0] f3;
    for (int c = 0; c < 400; c++) begin
      f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      // The store queue only presents when the buffer can take it.
      if (exp_q.size() < DEPTH && $urandom_range(0, 1) == 1)
        drive_store(32'h700 + 32'($urandom_range(0, 15)), $urandom, f3);
      else
        st_valid = 1'b0;
      dmem_wack = 1'($urandom_range(0, 1));
      ld_addr = 32'h700 + 32'($urandom_range(0, 15));
      #1;
      fwd_model(ld_addr, ev, ed);
      checks++;
      if ({wb_fwd_valid, wb_fwd_byte_vector, wb_fwd_data} !== {|ev, ev, ed}) begin
        errors++;
        $display("FAIL rand_fwd[%0d]: ld=%h valid=%b vec=%b data=%h, expected %b %b %h",
                 c, ld_addr, wb_fwd_valid, wb_fwd_byte_vector, wb_fwd_data, |ev, ev, ed);
      end
      checks++;
      if ({st_ready, wb_empty, dmem_wreq, st_misaligned} !==
          {exp_q.size() < DEPTH, exp_q.size() == 0, exp_q.size() > 0, exp_mis}) begin
        errors++;
        $display("FAIL rand_status[%0d]: ready=%b empty=%b wreq=%b mis=%b, expected %b %b %b %b",
                 c, st_ready, wb_empty, dmem_wreq, st_misaligned,
                 exp_q.size() < DEPTH, exp_q.size() == 0, exp_q.size() > 0, exp_mis);
      end
      tick();
    end
    drain_all();
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_sb_basic();
    test_fill_stall();
    test_forward();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_store_write_buffer
